// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter driving a shared N-bit JK flip-flop bank.
// A granted command applies its JK op to the masked bits for max(cnt,1) cycles.
module jk_bank_arbiter #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [1:0]    req0_op,
  input  logic [N-1:0]  req0_mask,
  input  logic [CW-1:0] req0_cnt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [1:0]    req1_op,
  input  logic [N-1:0]  req1_mask,
  input  logic [CW-1:0] req1_cnt,
  input  logic          abort,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic          done_aborted
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state, state_n;
  logic [1:0]    op_r, op_n;
  logic [N-1:0]  mask_r, mask_n, q_n, opval;
  logic [CW-1:0] rem, rem_n, cnt_sel;
  logic          id_r, id_n, ab_r, ab_n, last_grant, last_n, sel;

  // Tie goes to the requester that was not granted last.
  assign sel        = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = (state == IDLE) && req0_valid && !sel;
  assign req1_ready = (state == IDLE) && req1_valid && sel;
  assign cnt_sel    = sel ? req1_cnt : req0_cnt;

  always_comb begin
    state_n = state;
    op_n    = op_r;
    mask_n  = mask_r;
    rem_n   = rem;
    id_n    = id_r;
    ab_n    = ab_r;
    last_n  = last_grant;
    q_n     = q;
    case (op_r)
      2'b01:   opval = '0;
      2'b10:   opval = '1;
      2'b11:   opval = ~q;
      default: opval = q;
    endcase
    unique case (state)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          op_n    = sel ? req1_op : req0_op;
          mask_n  = sel ? req1_mask : req0_mask;
          id_n    = sel;
          ab_n    = 1'b0;
          rem_n   = (cnt_sel == '0) ? CW'(1) : cnt_sel;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (abort) begin
          ab_n    = 1'b1;
          state_n = DONE;
        end else begin
          q_n   = (q & ~mask_r) | (opval & mask_r);
          rem_n = rem - CW'(1);
          if (rem == CW'(1)) state_n = DONE;
        end
      end
      DONE: begin
        last_n  = id_r;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      op_r         <= '0;
      mask_r       <= '0;
      rem          <= '0;
      id_r         <= 1'b0;
      ab_r         <= 1'b0;
      last_grant   <= 1'b1;
      q            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      done_aborted <= 1'b0;
    end else begin
      state      <= state_n;
      op_r       <= op_n;
      mask_r     <= mask_n;
      rem        <= rem_n;
      id_r       <= id_n;
      ab_r       <= ab_n;
      last_grant <= last_n;
      q          <= q_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      if (state_n == DONE) begin
        done_id      <= id_n;
        done_aborted <= ab_n;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed and randomized bench for jk_bank_arbiter against a per-bit JK bank model.
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_mask, req1_mask;
  logic [3:0] req0_cnt, req1_cnt;
  logic       abort;
  logic [7:0] q;
  logic       busy, done, done_id, done_aborted;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q;
  logic        exp_last;

  jk_bank_arbiter #(.N(8), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_mask(req0_mask), .req0_cnt(req0_cnt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_mask(req1_mask), .req1_cnt(req1_cnt),
    .abort(abort), .q(q), .busy(busy), .done(done), .done_id(done_id),
    .done_aborted(done_aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One JK apply cycle: each masked bit follows its {j,k} pair.
  function automatic logic [7:0] jk_step(input logic [7:0] cur, input logic [1:0] op,
                                         input logic [7:0] m);
    logic [7:0] r;
    r = cur;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (op == 2'b01)      r[i] = 1'b0;
        else if (op == 2'b10) r[i] = 1'b1;
        else if (op == 2'b11) r[i] = !cur[i];
      end
    end
    return r;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge after accept.
  task automatic start_cmd(input bit id, input logic [1:0] op, input logic [7:0] mask,
                           input logic [3:0] cnt, input bit ab_idle);
    if (!id) begin
      req0_valid = 1'b1; req0_op = op; req0_mask = mask; req0_cnt = cnt;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_mask = mask; req1_cnt = cnt;
    end
    abort = ab_idle;
    #1;
    chk("ready0_idle", req0_ready, !id);
    chk("ready1_idle", req1_ready, id);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("ready0_exec", req0_ready, 0);
    chk("ready1_exec", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("busy_accept", busy, 1);
    chk("q_accept", q, exp_q);
    chk("done_accept", done, 0);
  endtask

  // Runs the EXEC edges; abort_at = k aborts on the k-th EXEC edge (0 = never).
  // Returns at the falling edge inside the DONE cycle.
  task automatic exec_cmd(input bit id, input logic [1:0] op, input logic [7:0] mask,
                          input logic [3:0] cnt, input int abort_at);
    int  eff;
    bit  aborted;
    bit  fin;
    eff = (cnt == 0) ? 1 : int'(cnt);
    aborted = 1'b0;
    for (int k = 1; k <= eff; k++) begin
      if (k == abort_at) abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k == abort_at) begin
        abort = 1'b0;
        aborted = 1'b1;
      end else begin
        exp_q = jk_step(exp_q, op, mask);
      end
      fin = aborted || (k == eff);
      chk("q_exec", q, exp_q);
      chk("busy_exec", busy, 1);
      chk("done_exec", done, fin);
      if (fin) begin
        chk("done_id", done_id, id);
        chk("done_aborted", done_aborted, aborted);
        exp_last = id;
        break;
      end
    end
  endtask

  task automatic to_idle(input bit ab);
    abort = ab;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
    chk("q_idle", q, exp_q);
  endtask

  task automatic full_cmd(input bit id, input logic [1:0] op, input logic [7:0] mask,
                          input logic [3:0] cnt, input int abort_at, input bit ab_idle);
    start_cmd(id, op, mask, cnt, ab_idle);
    exec_cmd(id, op, mask, cnt, abort_at);
    to_idle(ab_idle);
  endtask

  initial begin
    rst = 1'b0;
    abort = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_mask = '0; req0_cnt = '0;
    req1_valid = 1'b0; req1_op = '0; req1_mask = '0; req1_cnt = '0;
    exp_q = '0;
    exp_last = 1'b1;
    #1;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_ab", done_aborted, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a toggle command.
    start_cmd(1'b0, 2'b11, 8'hFF, 4'd5, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_q = jk_step(exp_q, 2'b11, 8'hFF);
      chk("q_pre_rst", q, exp_q);
    end
    rst = 1'b0;
    #1;
    exp_q = '0;
    exp_last = 1'b1;
    chk("async_rst_q", q, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("no_done_in_rst", done, 0);
    end
    rst = 1'b1;

    // Set, then toggle with cnt 3 and cnt 0.
    full_cmd(1'b0, 2'b10, 8'h0F, 4'd1, 0, 1'b0);
    chk("q_after_set", q, 8'h0F);
    full_cmd(1'b1, 2'b11, 8'h3C, 4'd3, 0, 1'b0);
    chk("q_after_tog3", q, 8'h33);
    full_cmd(1'b1, 2'b11, 8'h3C, 4'd0, 0, 1'b0);
    chk("q_after_tog0", q, 8'h0F);

    // Fairness from reset with both requesters continuously valid.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q = '0;
    exp_last = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01; req0_mask = 8'hFF; req0_cnt = 4'd1;
    req1_valid = 1'b1; req1_op = 2'b01; req1_mask = 8'hFF; req1_cnt = 4'd1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("fair_ready0", req0_ready, exp_last);
      chk("fair_ready1", req1_ready, !exp_last);
      chk("fair_grant_seq", req1_ready, g % 2);
      @(posedge clk);
      @(negedge clk);
      chk("fair_no_ready", req0_ready | req1_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("fair_done", done, 1);
      chk("fair_done_id", done_id, !exp_last);
      chk("fair_q", q, 0);
      exp_last = !exp_last;
      @(posedge clk);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Abort on the third EXEC edge of a 6-cycle toggle, then tie goes to req1.
    full_cmd(1'b0, 2'b11, 8'h01, 4'd6, 3, 1'b0);
    chk("q_after_abort", q, 8'h00);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("tie_after_abort0", req0_ready, 0);
    chk("tie_after_abort1", req1_ready, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("drop_valid_ready", req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("drop_valid_busy", busy, 0);

    // Hold command for 4 cycles, next command accepted right after done.
    full_cmd(1'b1, 2'b10, 8'hA5, 4'd1, 0, 1'b0);
    start_cmd(1'b0, 2'b00, 8'hFF, 4'd4, 1'b0);
    exec_cmd(1'b0, 2'b00, 8'hFF, 4'd4, 0);
    chk("q_after_hold", q, 8'hA5);
    req1_valid = 1'b1; req1_op = 2'b11; req1_mask = 8'hF0; req1_cnt = 4'd2;
    #1;
    chk("no_ready_in_done", req1_ready, 0);
    to_idle(1'b0);
    start_cmd(1'b1, 2'b11, 8'hF0, 4'd2, 1'b0);
    exec_cmd(1'b1, 2'b11, 8'hF0, 4'd2, 0);
    to_idle(1'b0);

    // Randomized commands with occasional aborts and stray abort in IDLE/DONE.
    for (int n = 0; n < 40; n++) begin
      bit         rid;
      logic [1:0] rop;
      logic [7:0] rmask;
      logic [3:0] rcnt;
      int         reff, rab;
      rid   = 1'($urandom);
      rop   = 2'($urandom);
      rmask = 8'($urandom);
      rcnt  = 4'($urandom_range(0, 6));
      reff  = (rcnt == 0) ? 1 : int'(rcnt);
      rab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, reff)) : 0;
      full_cmd(rid, rop, rmask, rcnt, rab, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
